spi_window_tx: RTL and testbench



---
 rtl/spi_window_tx_pkg.sv | 20 ++
 rtl/spi_bit_shifter.sv | 55 +++++
 rtl/spi_window_tx.sv | 92 +++++++++
 tb/tb_spi_window_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_window_tx_pkg.sv
`default_nettype none
// ============================================================================
// spi_window_tx_pkg : shared window constants and FSM state encoding
// Rev 1.0
// ============================================================================
package spi_window_tx_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int COUNT  = 12;

    // Encoding shared with the receive-side address generator.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spi_bit_shifter.sv
`default_nettype none
// ============================================================================
// spi_bit_shifter : mode-0 MSB-first byte serialiser with CLK_DIV half-period
// Rev 1.0
// ============================================================================
module spi_bit_shifter #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_byte_done
);

    localparam int PH_W  = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    logic [PH_W-1:0]   r_phase;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_sreg;
    logic              w_ph_last;

    assign w_ph_last   = (r_phase == PH_W'(2 * CLK_DIV - 1));
    // Shifting happens on the edge that also drops sclk, so mosi never moves while sclk is high.
    assign o_sclk      = i_en && (r_phase >= PH_W'(CLK_DIV));
    assign o_mosi      = r_sreg[DATA_W-1];
    assign o_byte_done = i_en && w_ph_last && (r_bit == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_sreg  <= '0;
        end else if (i_load) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_sreg  <= i_data;
        end else if (i_en) begin
            if (w_ph_last) begin
                r_phase <= '0;
                r_bit   <= r_bit + BIT_W'(1);
                r_sreg  <= {r_sreg[DATA_W-2:0], 1'b0};
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_window_tx.sv
`default_nettype none
// ============================================================================
// spi_window_tx : reads buffer[base+1..base+COUNT] and shifts it out over SPI
// Rev 1.0
// ============================================================================
module spi_window_tx #(
    parameter int DATA_W  = spi_window_tx_pkg::DATA_W,
    parameter int ADDR_W  = spi_window_tx_pkg::ADDR_W,
    parameter int COUNT   = spi_window_tx_pkg::COUNT,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] Posicion,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi
);
    import spi_window_tx_pkg::*;

    localparam int K_W = $clog2(COUNT + 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [K_W-1:0]    r_k;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              w_byte_done;

    spi_bit_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst         (reset),
        .i_load      (r_state == S_WAIT),
        .i_data      (rd_data),
        .i_en        (r_state == S_SHIFT),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .o_byte_done (w_byte_done)
    );

    assign rd_en   = (r_state == S_FETCH);
    assign rd_addr = r_rd_addr;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign cs_n    = !((r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_SHIFT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_k       <= '0;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= Posicion;
                        r_k       <= '0;
                        r_rd_addr <= Posicion + ADDR_W'(1);
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT:  r_state <= S_SHIFT;
                S_SHIFT: begin
                    if (w_byte_done) begin
                        if (r_k == K_W'(COUNT - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            // Next word lives at base + (k+1) + 1, modulo 2^ADDR_W.
                            r_k       <= r_k + K_W'(1);
                            r_rd_addr <= r_base + ADDR_W'(r_k) + ADDR_W'(2);
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_window_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_window_tx : scoreboard bench for spi_window_tx (default parameters)
// Rev 1.0
// ============================================================================
module tb_spi_window_tx;

    localparam int W     = 34;   // 2 + 2*CLK_DIV*DATA_W
    localparam int COUNT = 12;
    localparam int SPAN  = 408;  // COUNT*W : last cycle with cs_n low

    typedef struct {
        int         c;
        logic [9:0] a;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] Posicion = '0;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       busy, done, cs_n, sclk, mosi;
    logic       mode_a5 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rd_t        aq[$];
    logic [7:0] bq[$];
    int         dq[$];
    int         wq[$];

    spi_window_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .Posicion (Posicion),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffer: buffer[a] = a[7:0], or constant 0xA5.
    always @(posedge clk) if (rd_en) rd_data <= mode_a5 ? 8'hA5 : rd_addr[7:0];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected events as the DUT presents them.
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;
    int         nbits = 0;
    logic [7:0] acc = '0;
    always @(negedge clk) begin
        rd_t        r;
        logic [7:0] eb;
        logic       exp_cs;
        if (reset) begin
            nbits     = 0;
            prev_sclk = 1'b0;
        end else begin
            if (wq.size() > 0 && cyc > wq[0] + SPAN) void'(wq.pop_front());
            exp_cs = !(wq.size() > 0 && cyc >= wq[0] + 1 && cyc <= wq[0] + SPAN);
            check("cs_n", cs_n, exp_cs);
            if (rd_en) begin
                if (aq.size() == 0) check("unexpected_rd_en", 1, 0);
                else begin
                    r = aq.pop_front();
                    check("rd_en_cycle", cyc, r.c);
                    check("rd_addr", rd_addr, r.a);
                end
            end
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, dq.pop_front());
            end
            if (sclk && prev_sclk) check("mosi_stable_sclk_high", mosi, prev_mosi);
            if (sclk && !prev_sclk) begin
                acc = {acc[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (bq.size() == 0) check("unexpected_byte", 1, 0);
                    else begin
                        eb = bq.pop_front();
                        check("mosi_byte", acc, eb);
                    end
                end
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_window(input int s, input logic [9:0] base, input logic a5);
        for (int k = 0; k < COUNT; k++) begin
            logic [9:0] a;
            rd_t        r;
            a   = base + 10'(k + 1);
            r.c = s + 1 + W * k;
            r.a = a;
            aq.push_back(r);
            bq.push_back(a5 ? 8'hA5 : a[7:0]);
        end
        dq.push_back(s + SPAN + 1);
        wq.push_back(s);
    endtask

    task automatic begin_window(input logic [9:0] base, output int t0);
        start    = 1'b1;
        Posicion = base;
        t0       = cyc;
        push_window(t0, base, mode_a5);
        step();
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (aq.size() == 0 && bq.size() == 0 && dq.size() == 0) break;
            step();
        end
        if (i == bound) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending done events expected 0", name, dq.size());
            aq.delete(); bq.delete(); dq.delete(); wq.delete();
        end
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"},   rd_en,   0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_cs_n"},    cs_n,    1);
        check({tag, "_sclk"},    sclk,    0);
        check({tag, "_mosi"},    mosi,    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_vals("reset");

        // Basic window, base 100 -> addresses 101..112
        begin_window(10'd100, t0);
        drain("basic", 600);

        // Address wrap past 1023
        begin_window(10'd1020, t0);
        drain("wrap", 600);

        // Constant 0xA5 pattern
        mode_a5 = 1'b1;
        begin_window(10'd0, t0);
        drain("a5", 600);
        mode_a5 = 1'b0;

        // start pulses while busy must be ignored
        begin_window(10'd300, t0);
        while (cyc < t0 + 50) step();
        start = 1'b1; Posicion = 10'd700;
        step();
        start = 1'b0;
        while (cyc < t0 + 200) step();
        start = 1'b1; Posicion = 10'd900;
        step();
        start = 1'b0;
        drain("busy_start", 600);

        // Reset mid-frame at cycle 150
        begin_window(10'd50, t0);
        while (cyc < t0 + 150) step();
        reset = 1'b1;
        aq.delete(); bq.delete(); dq.delete(); wq.delete();
        step();
        check_reset_vals("midreset");
        reset = 1'b0;
        repeat (300) step();
        begin_window(10'd60, t0);
        drain("after_reset", 600);

        // Back-to-back: start held, windows every 410 cycles
        start    = 1'b1;
        Posicion = 10'd200;
        t0       = cyc;
        push_window(t0, 10'd200, 1'b0);
        push_window(t0 + 410, 10'd200, 1'b0);
        while (cyc < t0 + 420) step();
        start = 1'b0;
        drain("b2b", 1200);
        check("b2b_idle_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
